// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and write-op encoding for the pwm_multi block.
package pwm_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_A     = 8'h61;

  localparam logic [3:0] LVL_MAX = 4'd10;

  typedef enum logic {
    IDLE,
    GOT_CH
  } state_t;

  typedef enum logic [1:0] {
    OP_SET,
    OP_INC,
    OP_DEC
  } wr_op_t;

  function automatic logic ascii_is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending level written by commands, scaled threshold loaded
// at the period boundary, and the registered compare against the shared counter.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int PERIOD = 50000,
  parameter bit INVERT = 1'b0,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  wr_op_t           wr_op,
  input  logic [3:0]       wr_val,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  // One extra bit so a full-period threshold (L=10) is representable.
  localparam int THR_W = CNT_W + 1;
  localparam int STEP  = PERIOD / 10;

  logic [3:0]       lvl_pending;
  logic [3:0]       lvl_active;
  logic [THR_W-1:0] thr;
  logic             active_p1;

  function automatic logic [3:0] lvl_inc(input logic [3:0] l);
    return (l >= LVL_MAX) ? LVL_MAX : l + 4'd1;
  endfunction

  function automatic logic [3:0] lvl_dec(input logic [3:0] l);
    return (l == 4'd0) ? 4'd0 : l - 4'd1;
  endfunction

  // Pending level: updated by commands at any time; last write in a period wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_pending <= 4'd0;
    end else if (wr_en) begin
      case (wr_op)
        OP_INC:  lvl_pending <= lvl_inc(lvl_pending);
        OP_DEC:  lvl_pending <= lvl_dec(lvl_pending);
        default: lvl_pending <= wr_val;
      endcase
    end
  end

  // Active level and its threshold load together on the boundary edge, so the
  // compare never sees a half-updated duty within a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_active <= 4'd0;
      thr        <= '0;
    end else if (load) begin
      lvl_active <= lvl_pending;
      thr        <= THR_W'(lvl_pending) * THR_W'(STEP);
    end
  end

  // Active whenever the threshold is non-zero and the counter is below it;
  // L=0 yields a zero threshold and therefore a constant inactive output.
  assign active_p1 = (lvl_active != 4'd0) && ({1'b0, cnt} < thr);

  // Output register; reset drives the inactive pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= INVERT;
    end else begin
      pwm <= active_p1 ^ INVERT;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator driven by ASCII command byte pairs
// ("<channel letter><digit|+|->"), with duty changes applied at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int PERIOD = 50000,
  parameter bit INVERT = 1'b0,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [7:0]      cmd_data,
  output logic [N_CH-1:0] pwm,
  output logic            period_tick,
  output logic            cmd_err,
  output logic [4:0]      sel_ch
);

  logic [CNT_W-1:0] cnt;
  logic             boundary;
  state_t           state;
  state_t           state_nx;
  logic [4:0]       sel_nx;
  logic             err_nx;
  logic             wr_en;
  wr_op_t           wr_op;
  logic [3:0]       wr_val;
  logic [7:0]       ch_off;
  logic             ch_ok;

  assign boundary    = (cnt == CNT_W'(PERIOD - 1));
  assign period_tick = boundary;

  // Bytes below 'a' wrap to large offsets, so one compare covers both ends.
  assign ch_off = cmd_data - ASC_A;
  assign ch_ok  = (ch_off < 8'(N_CH));

  // Free-running period counter, never disturbed by commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Command FSM state, selected channel and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_ch  <= 5'd0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_nx;
      sel_ch  <= sel_nx;
      cmd_err <= err_nx;
    end
  end

  // Next-state decode; only cmd_valid cycles move the FSM or write a level.
  always_comb begin
    state_nx = state;
    sel_nx   = sel_ch;
    err_nx   = 1'b0;
    wr_en    = 1'b0;
    wr_op    = OP_SET;
    wr_val   = cmd_data[3:0];
    if (cmd_valid) begin
      case (state)
        IDLE: begin
          if (ch_ok) begin
            sel_nx   = ch_off[4:0];
            state_nx = GOT_CH;
          end else begin
            err_nx = 1'b1;
          end
        end
        GOT_CH: begin
          if (ascii_is_digit(cmd_data)) begin
            wr_en    = 1'b1;
            wr_op    = OP_SET;
            state_nx = IDLE;
          end else if (cmd_data == ASC_PLUS) begin
            wr_en    = 1'b1;
            wr_op    = OP_INC;
            state_nx = IDLE;
          end else if (cmd_data == ASC_MINUS) begin
            wr_en    = 1'b1;
            wr_op    = OP_DEC;
            state_nx = IDLE;
          end else if (ch_ok) begin
            sel_nx = ch_off[4:0];
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .PERIOD (PERIOD),
      .INVERT (INVERT),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en && (sel_ch == 5'(i))),
      .wr_op  (wr_op),
      .wr_val (wr_val),
      .load   (boundary),
      .cnt    (cnt),
      .pwm    (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a behavioural model pushes the expected
// outputs on every clock, and the sampler pops and compares on the falling edge.
// A second instance with INVERT=1 shares the stimulus and must show the complement.
module tb_pwm_multi;

  localparam int PERIOD = 100;
  localparam int N_CH   = 2;
  localparam int STEP   = PERIOD / 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;

  logic [1:0] pwm, pwm_i;
  logic       tick, tick_i, err, err_i;
  logic [4:0] sel, sel_i;

  pwm_multi #(.N_CH(N_CH), .PERIOD(PERIOD), .INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .pwm(pwm), .period_tick(tick), .cmd_err(err), .sel_ch(sel)
  );

  pwm_multi #(.N_CH(N_CH), .PERIOD(PERIOD), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .pwm(pwm_i), .period_tick(tick_i), .cmd_err(err_i), .sel_ch(sel_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pwm;
    logic       tick;
    logic       err;
    logic [4:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int m_cnt;
  int m_pend[N_CH];
  int m_act[N_CH];
  bit m_gch;
  int m_sel;

  // last sampled values and event counters
  logic [1:0] s_pwm, s_pwm_i;
  logic       s_tick;
  int         n_err_seen = 0;
  int         n_tick_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    int   idx;
    e = '0;
    if (!rst_n) begin
      m_cnt = 0;
      m_gch = 1'b0;
      m_sel = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_pend[i] = 0;
        m_act[i]  = 0;
      end
      sb.delete();
      sb.push_back(e);
    end else begin
      for (int i = 0; i < N_CH; i++) e.pwm[i] = (m_cnt < m_act[i] * STEP);
      if (m_cnt == PERIOD - 1)
        for (int i = 0; i < N_CH; i++) m_act[i] = m_pend[i];
      if (cmd_valid) begin
        idx = int'(cmd_data) - 97;  // 97 = 'a'
        if (!m_gch) begin
          if (idx >= 0 && idx < N_CH) begin
            m_sel = idx;
            m_gch = 1'b1;
          end else begin
            e.err = 1'b1;
          end
        end else if (cmd_data >= "0" && cmd_data <= "9") begin
          m_pend[m_sel] = int'(cmd_data) - 48;
          m_gch = 1'b0;
        end else if (cmd_data == "+") begin
          if (m_pend[m_sel] < 10) m_pend[m_sel]++;
          m_gch = 1'b0;
        end else if (cmd_data == "-") begin
          if (m_pend[m_sel] > 0) m_pend[m_sel]--;
          m_gch = 1'b0;
        end else if (idx >= 0 && idx < N_CH) begin
          m_sel = idx;
        end else begin
          e.err = 1'b1;
          m_gch = 1'b0;
        end
      end
      m_cnt  = (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
      e.tick = (m_cnt == PERIOD - 1);
      e.sel  = 5'(m_sel);
      sb.push_back(e);
    end
  end

  task automatic cyc();
    exp_t       e;
    logic [1:0] inv;
    @(negedge clk);
    s_pwm   = pwm;
    s_pwm_i = pwm_i;
    s_tick  = tick;
    if (err) n_err_seen++;
    if (tick) n_tick_seen++;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e   = sb.pop_front();
      inv = ~e.pwm;
      chk("pwm", 32'(pwm), 32'(e.pwm));
      chk("pwm_inv", 32'(pwm_i), 32'(inv));
      chk("tick", 32'(tick), 32'(e.tick));
      chk("tick_inv", 32'(tick_i), 32'(e.tick));
      chk("err", 32'(err), 32'(e.err));
      chk("err_inv", 32'(err_i), 32'(e.err));
      chk("sel", 32'(sel), 32'(e.sel));
      chk("sel_inv", 32'(sel_i), 32'(e.sel));
    end
  endtask

  task automatic send(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    cyc();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic run_to_tick();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!s_tick && k < 250);
    if (!s_tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  // Count active cycles over one full period that starts at the next boundary.
  task automatic measure(input string tag, input int exp_a, input int exp_b);
    int ha, hb, hai, hbi;
    ha = 0; hb = 0; hai = 0; hbi = 0;
    run_to_tick();
    cyc();
    repeat (PERIOD) begin
      cyc();
      ha  += int'(s_pwm[0]);
      hb  += int'(s_pwm[1]);
      hai += int'(s_pwm_i[0]);
      hbi += int'(s_pwm_i[1]);
    end
    chk({tag, "_duty_a"}, 32'(ha), 32'(exp_a));
    chk({tag, "_duty_b"}, 32'(hb), 32'(exp_b));
    chk({tag, "_duty_a_inv"}, 32'(hai), 32'(PERIOD - exp_a));
    chk({tag, "_duty_b_inv"}, 32'(hbi), 32'(PERIOD - exp_b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_pwm_inv", 32'(pwm_i), 32'd3);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    rst_n = 1'b1;
    sb.delete();

    // idle: ticks every PERIOD, no errors, outputs inactive
    n_tick_seen = 0;
    n_err_seen  = 0;
    repeat (300) cyc();
    chk("idle_ticks", 32'(n_tick_seen), 32'd3);
    chk("idle_errs", 32'(n_err_seen), 32'd0);

    // mid-period set of channel a
    repeat (40) cyc();
    send("a"); send("3");
    measure("a3", 30, 0);

    // channel b to 9, then two increments: second saturates at 10
    n_err_seen = 0;
    send("b"); send("9");
    send("b"); send("+");
    send("b"); send("+");
    measure("b10", 30, 100);
    chk("sat_errs", 32'(n_err_seen), 32'd0);

    // decrement at zero, then last write within a period wins
    send("a"); send("0");
    send("a"); send("-");
    measure("a0", 0, 100);
    send("a"); send("5");
    send("a"); send("2");
    measure("a2", 20, 100);
    chk("dec_errs", 32'(n_err_seen), 32'd0);

    // rejected bytes, then reselect in GOT_CH
    n_err_seen = 0;
    send("c");
    send("a"); send("x");
    chk("bad_errs", 32'(n_err_seen), 32'd2);
    send("a"); send("b"); send("4");
    measure("b4", 20, 40);
    chk("reselect_errs", 32'(n_err_seen), 32'd2);

    // reset at cnt=57 while a channel byte is outstanding
    send("b"); send("9");
    measure("b9", 20, 90);
    repeat (56) cyc();
    send("a");
    chk("pre_rst_pwm", 32'(pwm), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm), 32'd0);
    chk("async_rst_pwm_inv", 32'(pwm_i), 32'd3);
    chk("async_rst_sel", 32'(sel), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    sb.delete();
    send("a"); send("7");
    measure("a7", 70, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- N-channel PWM generator controlled by a stream of ASCII command bytes, e.g. from the UART receiver.
- Each byte pair selects a channel ('a', 'b', …) and then sets or nudges that channel's duty level.
- Duty changes are double-buffered and take effect only at a period boundary, so a mid-period update cannot produce a glitch or runt pulse.
- Sits between the command byte source and the motor/LED drive pins.

Parameters:
- N_CH, 2, number of PWM channels (1..26; channel k is selected by ASCII 'a'+k).
- PERIOD, 50000, clocks per PWM period; must be a multiple of 10.
- INVERT, 0, 1 = active-low outputs (the driven pin level is inverted, including at reset).
- CNT_W, $clog2(PERIOD), period counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  cmd_data is valid this cycle; one byte is consumed per valid cycle (no backpressure).
- cmd_data  in  8  ASCII command byte.
- pwm  out  N_CH  PWM outputs, registered.
- period_tick  out  1  one-cycle pulse when cnt == PERIOD-1.
- cmd_err  out  1  one-cycle pulse one clock after a rejected byte.
- sel_ch  out  5  currently selected channel index (debug).

Behaviour:
- Reset (async assert, sync release):
  - cnt=0; all active and pending levels = 0; FSM = IDLE; sel_ch=0.
  - period_tick=0; cmd_err=0; pwm = {N_CH{INVERT}}.
- Period counter:
  - cnt counts 0..PERIOD-1 and wraps to 0. It free-runs and is never reset by commands.
- Levels:
  - Each channel holds a 4-bit level L, range 0..10.
  - Threshold thr = L*(PERIOD/10), recomputed into a register when L_active loads.
  - pwm[i] registered as (cnt < thr_i) XOR INVERT, giving 1-cycle latency from cnt.
  - L=0 gives a constant inactive level. L=10 gives a constant active level. No off-by-one: exactly L*PERIOD/10 active cycles per period.
- Double buffering:
  - Commands write L_pending.
  - On the cycle where cnt == PERIOD-1, L_active <= L_pending for all channels; the new duty is visible from the next cnt==0.
  - A pending write on that same edge is not captured; it loads at the following boundary.
  - Multiple writes within one period: the last one wins.
- Command FSM, states IDLE and GOT_CH. Only cmd_valid cycles advance the FSM.
  - IDLE: 'a'..'a'+N_CH-1 → sel_ch=idx, go to GOT_CH. Any other byte → cmd_err, stay in IDLE.
  - GOT_CH, '0'..'9': L_pending[sel] = digit, go to IDLE.
  - GOT_CH, '+': L_pending[sel] = min(L_pending+1, 10), go to IDLE.
  - GOT_CH, '-': L_pending[sel] = max(L_pending-1, 0), go to IDLE.
  - GOT_CH, '+' or '-' at a saturation limit: value unchanged, no error.
  - GOT_CH, valid channel letter: reselect, stay in GOT_CH, no error.
  - GOT_CH, any other byte (including out-of-range letters, CR, LF): cmd_err, go to IDLE, no write.
  - '+' and '-' read L_pending, not L_active.
- Reset mid-period or mid-command: all state is lost immediately; outputs go to the inactive level asynchronously.

Decomposition:
- Package pwm_pkg:
  - ASCII constants (ASC_0, ASC_9, ASC_PLUS, ASC_MINUS, ASC_A).
  - LVL_MAX = 10.
  - FSM state enum {IDLE, GOT_CH}.
  - Function ascii_is_digit.
- Sub-module pwm_channel:
  - Holds L_pending, L_active and thr for one channel.
  - Performs the compare/invert.
  - Inputs: wr_en, wr_op (set/inc/dec), wr_val, load (boundary strobe), cnt.
- Top instantiates N_CH copies with a generate loop; FSM and counter live in the top.

Test Plan (PERIOD=100, N_CH=2, INVERT=0):
- Reset then idle: pwm=00 for 300 cycles; period_tick pulses every 100 cycles at cnt=99; cmd_err never asserts.
- Send 'a','3' mid-period: pwm[0] unchanged until the next boundary, then high exactly 30 cycles of every 100; pwm[1] stays 0.
- Send 'b','9' then '+','+' preceded by 'b' each time: level reaches 10 and the second '+' saturates; pwm[1] is constant 1 after the boundary; cmd_err=0.
- Send 'a','0','a','-': level stays 0, pwm[0] constant 0, no error. Then 'a','5','a','2' within one period: the next period shows 20 cycles high (last wins).
- Send 'c' (out of range), then 'a','x': cmd_err pulses twice, each one clock after the bad byte; levels unchanged; FSM in IDLE. Then 'a','b','4': channel b gets 40% with no error.
- Assert rst_n low at cnt=57 while in GOT_CH: pwm goes to 00 asynchronously. After release, 'a','7' yields 70% duty with cnt restarted from 0. Repeat with INVERT=1 and check complemented waveforms and reset level 1.
